mcp3008_scanner: RTL

//  SPI master that scans the MCP3008 10-bit ADC round-robin over NUM_CH single-ended channels.

---
 rtl/adc_pkg.sv | 32 +++
 rtl/adc_sclk_gen.sv | 70 +++++++
 rtl/mcp3008_scanner.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared types and constants for the MCP3008 scanner.
//   adc_state_t  - scanner FSM states
//   ADC_*        - frame geometry (result width, SCLK edges per frame, command/data edges)
//   adc_cmd_bit  - DIN value to present before a given SCLK rising edge
package adc_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} adc_state_t;

  localparam int ADC_BITS            = 10;
  localparam int ADC_FRAME_EDGES     = 17;
  localparam int ADC_DATA_FIRST_EDGE = 8;
  localparam int ADC_CMD_BITS        = 5;
  localparam int ADC_EDGE_W          = 5;

  // Command for rising edges 1..5 is start, SGL/DIFF=1, D2, D1, D0; DIN idles low after that.
  function automatic logic adc_cmd_bit(input logic [ADC_EDGE_W-1:0] edge_no,
                                       input logic [2:0]            ch);
    logic bit_v;
    bit_v = 1'b0;
    if (edge_no <= ADC_EDGE_W'(ADC_CMD_BITS)) begin
      case (edge_no)
        5'd1, 5'd2: bit_v = 1'b1;
        5'd3:       bit_v = ch[2];
        5'd4:       bit_v = ch[1];
        5'd5:       bit_v = ch[0];
        default:    bit_v = 1'b0;
      endcase
    end
    return bit_v;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: SPI SCLK generator for the MCP3008 scanner.
//   clk, rst_n  - system clock, async active-low reset
//   start       - clears the generator (SCLK low, counters zero) for a new frame
//   run         - advance the half-period counter
//   ad_clk      - registered SCLK, idle low
//   rise_stb    - SCLK rises on the coming clk edge
//   fall_stb    - SCLK falls on the coming clk edge
//   edge_cnt    - rising edges produced since start (0..17)
module adc_sclk_gen
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  run,
  output logic                  ad_clk,
  output logic                  rise_stb,
  output logic                  fall_stb,
  output logic [ADC_EDGE_W-1:0] edge_cnt
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ad_clk_q, ad_clk_d;
  logic [ADC_EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic                  half_end;

  // Strobes are combinational look-aheads so the scanner can act on the
  // same clk edge that moves SCLK.
  always_comb begin
    half_end   = run && (cnt_q == CNT_W'(CLK_DIV - 1));
    rise_stb   = half_end && !ad_clk_q;
    fall_stb   = half_end && ad_clk_q;
    cnt_d      = cnt_q;
    ad_clk_d   = ad_clk_q;
    edge_cnt_d = edge_cnt_q;
    if (start) begin
      cnt_d      = '0;
      ad_clk_d   = 1'b0;
      edge_cnt_d = '0;
    end else if (run) begin
      if (half_end) begin
        cnt_d    = '0;
        ad_clk_d = !ad_clk_q;
        if (!ad_clk_q) edge_cnt_d = edge_cnt_q + ADC_EDGE_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      ad_clk_q   <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      ad_clk_q   <= ad_clk_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign ad_clk   = ad_clk_q;
  assign edge_cnt = edge_cnt_q;

endmodule

// File: rtl/mcp3008_scanner.sv
// mcp3008_scanner: self-timed SPI master scanning MCP3008 channels 0..NUM_CH-1 round-robin.
//   clk, rst_n    - system clock, async active-low reset (aborts a frame, cs_n high at once)
//   enable        - 1 runs the scan; 0 lets the current frame finish, then idles
//   ad_clk, cs_n, din - SPI SCLK (idle low), chip select, command out
//   dout          - SPI data in, asynchronous; synchronised with two flops
//   sample_valid  - one-clk pulse per completed conversion, with sample_ch / sample_data
//   ch_data       - latest result per channel, slot i at [10*i +: 10]
//   busy          - high whenever the FSM is not IDLE
// Frame: CS_n falls into SETUP, which is also the low half of SCLK period 1; 17 SCLK
// periods (34*CLK_DIV clk) later CS_n rises into DONE, then CS_IDLE_CYC clk of GAP.
module mcp3008_scanner
  import adc_pkg::*;
#(
  parameter int CLK_DIV     = 25,
  parameter int NUM_CH      = 8,
  parameter int CS_IDLE_CYC = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  ad_clk,
  output logic                  cs_n,
  output logic                  din,
  input  logic                  dout,
  output logic                  sample_valid,
  output logic [2:0]            sample_ch,
  output logic [ADC_BITS-1:0]   sample_data,
  output logic [8*ADC_BITS-1:0] ch_data,
  output logic                  busy
);

  localparam int GAP_W = (CS_IDLE_CYC > 1) ? $clog2(CS_IDLE_CYC) : 1;

  adc_state_t            state_q, state_d;
  logic                  cs_n_q, cs_n_d;
  logic                  din_q, din_d;
  logic                  sample_valid_q, sample_valid_d;
  logic [2:0]            sample_ch_q, sample_ch_d;
  logic [ADC_BITS-1:0]   sample_data_q, sample_data_d;
  logic [8*ADC_BITS-1:0] ch_data_q, ch_data_d;
  logic                  busy_q, busy_d;
  logic [2:0]            ptr_q, ptr_d, ptr_next;
  logic [ADC_BITS-1:0]   shift_q, shift_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  dout_s1_q, dout_s2_q;

  logic                  start, run;
  logic                  rise_stb, fall_stb;
  logic [ADC_EDGE_W-1:0] edge_cnt, next_edge;

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .run      (run),
    .ad_clk   (ad_clk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .edge_cnt (edge_cnt)
  );

  always_comb begin
    state_d        = state_q;
    cs_n_d         = cs_n_q;
    din_d          = din_q;
    sample_valid_d = 1'b0;
    sample_ch_d    = sample_ch_q;
    sample_data_d  = sample_data_q;
    ch_data_d      = ch_data_q;
    ptr_d          = ptr_q;
    shift_d        = shift_q;
    gap_d          = gap_q;
    start          = 1'b0;
    run            = (state_q == SETUP) || (state_q == SHIFT);
    next_edge      = edge_cnt + ADC_EDGE_W'(1);
    ptr_next       = (ptr_q == 3'(NUM_CH - 1)) ? 3'd0 : ptr_q + 3'd1;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          din_d   = 1'b1;
          start   = 1'b1;
        end
      end
      SETUP: begin
        if (rise_stb) state_d = SHIFT;
      end
      SHIFT: begin
        // The synchronised bit lags DOUT by 2 clk; DOUT has been stable since
        // the previous SCLK fall, so it is safe to take it as SCLK rises.
        if (rise_stb && (next_edge >= ADC_EDGE_W'(ADC_DATA_FIRST_EDGE)))
          shift_d = {shift_q[ADC_BITS-2:0], dout_s2_q};
        if (fall_stb) begin
          if (edge_cnt == ADC_EDGE_W'(ADC_FRAME_EDGES)) begin
            state_d        = DONE;
            cs_n_d         = 1'b1;
            din_d          = 1'b0;
            sample_valid_d = 1'b1;
            sample_data_d  = shift_q;
            sample_ch_d    = ptr_q;
            ch_data_d[ADC_BITS*ptr_q +: ADC_BITS] = shift_q;
            ptr_d          = ptr_next;
          end else begin
            din_d = adc_cmd_bit(next_edge, ptr_q);
          end
        end
      end
      DONE: begin
        state_d = GAP;
        gap_d   = '0;
      end
      GAP: begin
        if (gap_q == GAP_W'(CS_IDLE_CYC - 1)) begin
          if (enable) begin
            state_d = SETUP;
            cs_n_d  = 1'b0;
            din_d   = 1'b1;
            start   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cs_n_q         <= 1'b1;
      din_q          <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      sample_data_q  <= '0;
      ch_data_q      <= '0;
      busy_q         <= 1'b0;
      ptr_q          <= '0;
      shift_q        <= '0;
      gap_q          <= '0;
      dout_s1_q      <= 1'b0;
      dout_s2_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cs_n_q         <= cs_n_d;
      din_q          <= din_d;
      sample_valid_q <= sample_valid_d;
      sample_ch_q    <= sample_ch_d;
      sample_data_q  <= sample_data_d;
      ch_data_q      <= ch_data_d;
      busy_q         <= busy_d;
      ptr_q          <= ptr_d;
      shift_q        <= shift_d;
      gap_q          <= gap_d;
      dout_s1_q      <= dout;
      dout_s2_q      <= dout_s1_q;
    end
  end

  assign cs_n         = cs_n_q;
  assign din          = din_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign sample_data  = sample_data_q;
  assign ch_data      = ch_data_q;
  assign busy         = busy_q;

endmodule
